// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: arbitrates NMI/BRK/IRQ, pushes PC and P, fetches the vector.
// Optional feature macro: VECTORED_IRQ_EN (per-channel IRQ vectors).
module int_seq #(
   parameter int unsigned NIRQ       = 4,
   parameter logic [7:0]  STACK_PAGE = 8'h01,
   parameter logic [15:0] VEC_TOP    = 16'hFFFF
) (
   input  logic            clk,
   input  logic            res,
   input  logic            rdy,
   input  logic [NIRQ-1:0] irq,
   input  logic            nmi,
   input  logic            brk_req,
   input  logic            start,
   input  logic            i_flag,
   input  logic [15:0]     pc_in,
   input  logic [7:0]      p_in,
   input  logic [7:0]      sp_in,
   input  logic [7:0]      d_in,
   output logic [15:0]     add_bus,
   output logic [7:0]      d_out,
   output logic            write_en,
   output logic            busy,
   output logic            pc_load,
   output logic [15:0]     pc_out,
   output logic [7:0]      sp_out,
   output logic            set_i,
   output logic [3:0]      src
);

   localparam int unsigned IW = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PUSH_H = 3'd1,
      PUSH_L = 3'd2,
      PUSH_P = 3'd3,
      VEC_L  = 3'd4,
      VEC_H  = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    sp_q, sp_d;
   logic [7:0]    pc_lo_q, pc_lo_d;
   logic [7:0]    p_q, p_d;
   logic [15:0]   vec_q, vec_d;
   logic [7:0]    vec_l_q, vec_l_d;
   logic          nmi_prev_q;
   logic          nmi_pend_q, nmi_pend_d;
   logic          rst_pend_q, rst_pend_d;
   logic [15:0]   add_bus_d;
   logic [7:0]    d_out_d;
   logic          write_en_d;
   logic          busy_d;
   logic          pc_load_d;
   logic [15:0]   pc_out_d;
   logic [7:0]    sp_out_d;
   logic          set_i_d;
   logic [3:0]    src_d;

   logic          irq_hit;
   logic [IW-1:0] irq_idx;
   logic          is_rst;
   logic          accept;

   // Lowest-index active-low IRQ line wins.
   always_comb begin
      irq_hit = 1'b0;
      irq_idx = '0;
      for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
         if (!irq[i]) begin
            irq_hit = 1'b1;
            irq_idx = IW'(i);
         end
      end
   end

   // The reset sequence is the only one reporting cause 0; its pushes become reads.
   assign is_rst = (src == 4'd0);

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      pc_lo_d    = pc_lo_q;
      p_d        = p_q;
      vec_d      = vec_q;
      vec_l_d    = vec_l_q;
      nmi_pend_d = nmi_pend_q;
      rst_pend_d = rst_pend_q;
      add_bus_d  = add_bus;
      d_out_d    = d_out;
      write_en_d = write_en;
      pc_load_d  = 1'b0;
      pc_out_d   = pc_out;
      sp_out_d   = sp_out;
      set_i_d    = 1'b0;
      src_d      = src;
      accept     = 1'b0;

      case (state_q)
         IDLE: begin
            if (rst_pend_q) begin
               state_d    = PUSH_H;
               rst_pend_d = 1'b0;
               sp_d       = sp_in;
               pc_lo_d    = 8'h00;
               p_d        = 8'h00;
               src_d      = 4'd0;
               vec_d      = VEC_TOP - 16'd3;
               add_bus_d  = {STACK_PAGE, sp_in};
               d_out_d    = 8'h00;
               write_en_d = 1'b1;
            end else if (start && rdy) begin
               if (nmi_pend_q) begin
                  accept     = 1'b1;
                  nmi_pend_d = 1'b0;
                  src_d      = 4'd1;
                  vec_d      = VEC_TOP - 16'd5;
                  p_d        = p_in & 8'hEF;
               end else if (brk_req) begin
                  accept = 1'b1;
                  src_d  = 4'd2;
                  vec_d  = VEC_TOP - 16'd1;
                  p_d    = p_in | 8'h30;
               end else if (irq_hit && !i_flag) begin
                  accept = 1'b1;
                  src_d  = {1'b1, irq_idx};
                  p_d    = p_in & 8'hEF;
`ifdef VECTORED_IRQ_EN
                  vec_d  = (irq_idx == '0) ? VEC_TOP - 16'd1
                                           : VEC_TOP - 16'd5 - 16'({irq_idx, 1'b0});
`else
                  vec_d  = VEC_TOP - 16'd1;
`endif
               end
               if (accept) begin
                  state_d    = PUSH_H;
                  sp_d       = sp_in;
                  pc_lo_d    = pc_in[7:0];
                  add_bus_d  = {STACK_PAGE, sp_in};
                  d_out_d    = pc_in[15:8];
                  write_en_d = 1'b0;
               end
            end
         end
         PUSH_H: begin
            if (rdy) begin
               state_d    = PUSH_L;
               sp_d       = sp_q - 8'd1;
               add_bus_d  = {STACK_PAGE, sp_q - 8'd1};
               d_out_d    = is_rst ? 8'h00 : pc_lo_q;
               write_en_d = is_rst;
            end
         end
         PUSH_L: begin
            if (rdy) begin
               state_d    = PUSH_P;
               sp_d       = sp_q - 8'd1;
               add_bus_d  = {STACK_PAGE, sp_q - 8'd1};
               d_out_d    = is_rst ? 8'h00 : p_q;
               write_en_d = is_rst;
            end
         end
         PUSH_P: begin
            if (rdy) begin
               state_d    = VEC_L;
               sp_d       = sp_q - 8'd1;
               add_bus_d  = vec_q;
               d_out_d    = 8'h00;
               write_en_d = 1'b1;
            end
         end
         VEC_L: begin
            if (rdy) begin
               state_d   = VEC_H;
               vec_l_d   = d_in;
               add_bus_d = vec_q + 16'd1;
            end
         end
         VEC_H: begin
            if (rdy) begin
               state_d   = DONE;
               pc_out_d  = {d_in, vec_l_q};
               sp_out_d  = sp_q;
               pc_load_d = 1'b1;
               set_i_d   = 1'b1;
               add_bus_d = 16'h0000;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new edge outranks the clear so an edge during acceptance stays pending.
      if (nmi_prev_q && !nmi) begin
         nmi_pend_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      nmi_prev_q <= nmi;
      if (res) begin
         state_q    <= IDLE;
         sp_q       <= 8'h00;
         pc_lo_q    <= 8'h00;
         p_q        <= 8'h00;
         vec_q      <= 16'h0000;
         vec_l_q    <= 8'h00;
         nmi_pend_q <= 1'b0;
         rst_pend_q <= 1'b1;
         add_bus    <= 16'h0000;
         d_out      <= 8'h00;
         write_en   <= 1'b1;
         busy       <= 1'b0;
         pc_load    <= 1'b0;
         pc_out     <= 16'h0000;
         sp_out     <= 8'h00;
         set_i      <= 1'b0;
         src        <= 4'd0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         pc_lo_q    <= pc_lo_d;
         p_q        <= p_d;
         vec_q      <= vec_d;
         vec_l_q    <= vec_l_d;
         nmi_pend_q <= nmi_pend_d;
         rst_pend_q <= rst_pend_d;
         add_bus    <= add_bus_d;
         d_out      <= d_out_d;
         write_en   <= write_en_d;
         busy       <= busy_d;
         pc_load    <= pc_load_d;
         pc_out     <= pc_out_d;
         sp_out     <= sp_out_d;
         set_i      <= set_i_d;
         src        <= src_d;
      end
   end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: bus-cycle and completion scoreboards fed from the stimulus.
module tb_int_seq;

   localparam int unsigned NIRQ = 4;

`ifdef VECTORED_IRQ_EN
   localparam logic [15:0] IRQ3_VEC = 16'hFFF4;
   localparam logic [15:0] IRQ3_PC  = 16'hBC9A;
`else
   localparam logic [15:0] IRQ3_VEC = 16'hFFFE;
   localparam logic [15:0] IRQ3_PC  = 16'h5678;
`endif

   logic            clk = 1'b0;
   logic            res, rdy, nmi, brk_req, start, i_flag;
   logic [NIRQ-1:0] irq;
   logic [15:0]     pc_in;
   logic [7:0]      p_in, sp_in, d_in;
   logic [15:0]     add_bus;
   logic [7:0]      d_out;
   logic            write_en, busy, pc_load, set_i;
   logic [15:0]     pc_out;
   logic [7:0]      sp_out;
   logic [3:0]      src;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        we;
      logic        chk_d;
   } bus_t;

   typedef struct {
      logic [15:0] pc;
      logic [7:0]  sp;
      logic [3:0]  src;
   } done_t;

   bus_t  exp_bus[$];
   done_t exp_done[$];
   logic [7:0] vmem [16];
   int tests = 0;
   int fails = 0;
   int lat;

   int_seq #(.NIRQ(NIRQ), .STACK_PAGE(8'h01), .VEC_TOP(16'hFFFF)) dut (
      .clk(clk), .res(res), .rdy(rdy), .irq(irq), .nmi(nmi), .brk_req(brk_req),
      .start(start), .i_flag(i_flag), .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in),
      .d_in(d_in), .add_bus(add_bus), .d_out(d_out), .write_en(write_en),
      .busy(busy), .pc_load(pc_load), .pc_out(pc_out), .sp_out(sp_out),
      .set_i(set_i), .src(src)
   );

   always #5 clk = ~clk;

   assign d_in = (add_bus[15:4] == 12'hFFF) ? vmem[add_bus[3:0]] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_bus(input logic [15:0] a, input logic [7:0] d, input logic we,
                           input logic chk_d);
      bus_t b;
      b.a = a; b.d = d; b.we = we; b.chk_d = chk_d;
      exp_bus.push_back(b);
   endtask

   task automatic push_done(input logic [15:0] pc, input logic [7:0] sp, input logic [3:0] s);
      done_t e;
      e.pc = pc; e.sp = sp; e.src = s;
      exp_done.push_back(e);
   endtask

   // Drives rdy per cycle after the accept edge and counts cycles up to the pc_load pulse.
   task automatic run_seq(input int stall_at, input int stall_len, input logic [15:0] ha,
                          input logic [7:0] hd, input logic hwe, output int n);
      n = 0;
      for (int c = 1; c <= 40; c++) begin
         rdy = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
         @(negedge clk);
         if (stall_len > 0 && c >= stall_at && c <= stall_at + stall_len) begin
            chk("hold_add_bus", 32'(add_bus), 32'(ha));
            chk("hold_d_out", 32'(d_out), 32'(hd));
            chk("hold_write_en", 32'(write_en), 32'(hwe));
         end
         if (pc_load === 1'b1) begin
            n = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      rdy = 1'b1;
   endtask

   task automatic accept_edge();
      @(posedge clk);
      #1;
      start   = 1'b0;
      brk_req = 1'b0;
   endtask

   // Scoreboard monitor: each completed bus cycle and each completion pulse.
   always @(negedge clk) begin
      if (busy === 1'b1 && rdy === 1'b1 && pc_load !== 1'b1) begin
         tests++;
         assert (exp_bus.size() != 0) else begin
            fails++;
            $error("FAIL bus_extra observed=%0h expected=none", add_bus);
         end
         if (exp_bus.size() != 0) begin
            bus_t e;
            e = exp_bus.pop_front();
            chk("bus_addr", 32'(add_bus), 32'(e.a));
            chk("bus_we", 32'(write_en), 32'(e.we));
            if (e.chk_d) chk("bus_data", 32'(d_out), 32'(e.d));
         end
      end
      if (pc_load === 1'b1) begin
         tests++;
         assert (exp_done.size() != 0) else begin
            fails++;
            $error("FAIL done_extra observed=%0h expected=none", pc_out);
         end
         if (exp_done.size() != 0) begin
            done_t e;
            e = exp_done.pop_front();
            chk("pc_out", 32'(pc_out), 32'(e.pc));
            chk("sp_out", 32'(sp_out), 32'(e.sp));
            chk("src", 32'(src), 32'(e.src));
            chk("set_i", 32'(set_i), 32'd1);
            chk("busy_done", 32'(busy), 32'd1);
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) vmem[i] = 8'h00;
      vmem[4'hA] = 8'hEF; vmem[4'hB] = 8'hBE;
      vmem[4'hC] = 8'h34; vmem[4'hD] = 8'h12;
      vmem[4'hE] = 8'h78; vmem[4'hF] = 8'h56;
      vmem[4'h4] = 8'h9A; vmem[4'h5] = 8'hBC;

      res = 1'b1; rdy = 1'b1; nmi = 1'b1; brk_req = 1'b0; start = 1'b0; i_flag = 1'b0;
      irq = '1; pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_add_bus", 32'(add_bus), 32'h0);
      chk("rst_d_out", 32'(d_out), 32'h0);
      chk("rst_write_en", 32'(write_en), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_pc_load", 32'(pc_load), 32'h0);
      chk("rst_set_i", 32'(set_i), 32'h0);
      chk("rst_pc_out", 32'(pc_out), 32'h0);
      chk("rst_sp_out", 32'(sp_out), 32'h0);
      chk("rst_src", 32'(src), 32'h0);

      // Reset sequence: three stack reads then vector FFFC/FFFD
      @(posedge clk); #1;
      res = 1'b0; sp_in = 8'hFD;
      push_bus(16'h01FD, 8'h00, 1'b1, 1'b1);
      push_bus(16'h01FC, 8'h00, 1'b1, 1'b1);
      push_bus(16'h01FB, 8'h00, 1'b1, 1'b1);
      push_bus(16'hFFFC, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFD, 8'h00, 1'b1, 1'b0);
      push_done(16'h1234, 8'hFA, 4'd0);
      accept_edge();
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_reset", 32'(lat), 32'd6);

      // IRQ channel 2
      @(posedge clk); #1;
      irq = 4'b1011; i_flag = 1'b0; pc_in = 16'hC005; p_in = 8'hA1; sp_in = 8'hF0; start = 1'b1;
      push_bus(16'h01F0, 8'hC0, 1'b0, 1'b1);
      push_bus(16'h01EF, 8'h05, 1'b0, 1'b1);
      push_bus(16'h01EE, 8'hA1, 1'b0, 1'b1);
      push_bus(16'hFFFE, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFF, 8'h00, 1'b1, 1'b0);
      push_done(16'h5678, 8'hED, 4'd10);
      accept_edge();
      irq = '1;
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_irq2", 32'(lat), 32'd6);

      // NMI edge pending with irq[0] low: NMI first, then IRQ 0
      @(posedge clk); #1;
      nmi = 1'b0; irq = 4'b1110;
      @(posedge clk); #1;
      pc_in = 16'h2000; p_in = 8'h35; sp_in = 8'h80; start = 1'b1;
      push_bus(16'h0180, 8'h20, 1'b0, 1'b1);
      push_bus(16'h017F, 8'h00, 1'b0, 1'b1);
      push_bus(16'h017E, 8'h25, 1'b0, 1'b1);
      push_bus(16'hFFFA, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFB, 8'h00, 1'b1, 1'b0);
      push_done(16'hBEEF, 8'h7D, 4'd1);
      accept_edge();
      nmi = 1'b1;
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_nmi", 32'(lat), 32'd6);
      @(posedge clk); #1;
      pc_in = 16'h2010; sp_in = 8'h7D; start = 1'b1;
      push_bus(16'h017D, 8'h20, 1'b0, 1'b1);
      push_bus(16'h017C, 8'h10, 1'b0, 1'b1);
      push_bus(16'h017B, 8'h25, 1'b0, 1'b1);
      push_bus(16'hFFFE, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFF, 8'h00, 1'b1, 1'b0);
      push_done(16'h5678, 8'h7A, 4'd8);
      accept_edge();
      irq = '1;
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_irq0", 32'(lat), 32'd6);

      // BRK with P=00, stack wrap from 00, rdy low 3 cycles in PUSH_L
      @(posedge clk); #1;
      brk_req = 1'b1; pc_in = 16'hABCD; p_in = 8'h00; sp_in = 8'h00; start = 1'b1;
      push_bus(16'h0100, 8'hAB, 1'b0, 1'b1);
      push_bus(16'h01FF, 8'hCD, 1'b0, 1'b1);
      push_bus(16'h01FE, 8'h30, 1'b0, 1'b1);
      push_bus(16'hFFFE, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFF, 8'h00, 1'b1, 1'b0);
      push_done(16'h5678, 8'hFD, 4'd2);
      accept_edge();
      run_seq(2, 3, 16'h01FF, 8'hCD, 1'b0, lat);
      chk("lat_brk_stall", 32'(lat), 32'd9);

      // i_flag masks IRQ: no sequence starts
      @(posedge clk); #1;
      irq = 4'b0111; i_flag = 1'b1; start = 1'b1;
      accept_edge();
      @(negedge clk);
      chk("masked_busy", 32'(busy), 32'd0);

      // IRQ channel 3 (vector depends on build option)
      @(posedge clk); #1;
      i_flag = 1'b0; pc_in = 16'h1111; p_in = 8'hC3; sp_in = 8'h40; start = 1'b1;
      push_bus(16'h0140, 8'h11, 1'b0, 1'b1);
      push_bus(16'h013F, 8'h11, 1'b0, 1'b1);
      push_bus(16'h013E, 8'hC3, 1'b0, 1'b1);
      push_bus(IRQ3_VEC, 8'h00, 1'b1, 1'b0);
      push_bus(IRQ3_VEC + 16'd1, 8'h00, 1'b1, 1'b0);
      push_done(IRQ3_PC, 8'h3D, 4'd11);
      accept_edge();
      irq = '1;
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_irq3", 32'(lat), 32'd6);

      // Reset during PUSH_P aborts, then the reset sequence restarts
      @(posedge clk); #1;
      brk_req = 1'b1; pc_in = 16'h4321; p_in = 8'h01; sp_in = 8'h50; start = 1'b1;
      push_bus(16'h0150, 8'h43, 1'b0, 1'b1);
      push_bus(16'h014F, 8'h21, 1'b0, 1'b1);
      push_bus(16'h014E, 8'h31, 1'b0, 1'b1);
      accept_edge();
      @(posedge clk); #1;
      @(posedge clk); #1;
      res = 1'b1;
      @(posedge clk); #1;
      chk("abort_write_en", 32'(write_en), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_add_bus", 32'(add_bus), 32'h0);
      @(posedge clk); #1;
      res = 1'b0; sp_in = 8'h20;
      push_bus(16'h0120, 8'h00, 1'b1, 1'b1);
      push_bus(16'h011F, 8'h00, 1'b1, 1'b1);
      push_bus(16'h011E, 8'h00, 1'b1, 1'b1);
      push_bus(16'hFFFC, 8'h00, 1'b1, 1'b0);
      push_bus(16'hFFFD, 8'h00, 1'b1, 1'b0);
      push_done(16'h1234, 8'h1D, 4'd0);
      accept_edge();
      run_seq(0, 0, 16'h0, 8'h0, 1'b0, lat);
      chk("lat_reset2", 32'(lat), 32'd6);

      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
      chk("done_queue_empty", 32'(exp_done.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
